// File: rtl/soc_bus_pkg.sv
// rtl/soc_bus_pkg.sv - shared encodings and constants for the SoC memory bus arbiter
package soc_bus_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

  localparam logic [31:0] WDOG_FILL = 32'hDEAD_BEEF;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - combinational two-way round-robin grant; i_prio names the preferred port
module rr_arbiter2
  import soc_bus_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_prio,
  output logic [1:0] o_gnt
);

  always_comb begin
    o_gnt = 2'b00;
    if (i_req[PORT_CPU] && (!i_req[PORT_AUX] || (i_prio == PORT_CPU))) begin
      o_gnt[PORT_CPU] = 1'b1;
    end else if (i_req[PORT_AUX]) begin
      o_gnt[PORT_AUX] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-master round-robin arbiter for the SoC memory bus
// Optional watchdog enabled by defining MEM_BUS_ARB_TIMEOUT_EN.
module mem_bus_arbiter
  import soc_bus_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_valid,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [3:0]        m0_wstrb,
  output logic              m0_ready,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_valid,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [3:0]        m1_wstrb,
  output logic              m1_ready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              s_valid,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  output logic [3:0]        s_wstrb,
  input  logic              s_ready,
  input  logic [DATA_W-1:0] s_rdata,
  output logic              m_err
);

  state_e     r_state;
  logic       r_owner;
  logic       r_prio;
  logic [1:0] w_gnt;
  logic       w_tmo;
  logic       w_fin;

  rr_arbiter2 u_rr (
    .i_req  ({m1_valid, m0_valid}),
    .i_prio (r_prio),
    .o_gnt  (w_gnt)
  );

`ifdef MEM_BUS_ARB_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] r_wdog;

  // Held at zero while idle, so every transaction starts counting from 0.
  always_ff @(posedge clk) begin
    if (reset || (r_state == ST_IDLE)) begin
      r_wdog <= '0;
    end else if (!s_ready) begin
      r_wdog <= r_wdog + 1'b1;
    end
  end

  assign w_tmo = (r_state == ST_BUSY) && !s_ready && (r_wdog == TW'(TIMEOUT_CYCLES - 1));
`else
  // Watchdog absent; TIMEOUT_CYCLES stays in the interface for both builds.
  assign w_tmo = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

  assign w_fin    = (r_state == ST_BUSY) && (s_ready || w_tmo);
  assign m0_ready = w_fin && (r_owner == PORT_CPU);
  assign m1_ready = w_fin && (r_owner == PORT_AUX);
  assign m_err    = w_tmo;
  assign m0_rdata = (w_tmo && (r_owner == PORT_CPU)) ? DATA_W'(WDOG_FILL) : s_rdata;
  assign m1_rdata = (w_tmo && (r_owner == PORT_AUX)) ? DATA_W'(WDOG_FILL) : s_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_owner <= PORT_CPU;
      r_prio  <= PORT_CPU;
      s_valid <= 1'b0;
      s_addr  <= '0;
      s_wdata <= '0;
      s_wstrb <= '0;
    end else if (r_state == ST_IDLE) begin
      if (w_gnt[PORT_AUX]) begin
        r_owner <= PORT_AUX;
        s_addr  <= m1_addr;
        s_wdata <= m1_wdata;
        s_wstrb <= m1_wstrb;
        s_valid <= 1'b1;
        r_state <= ST_BUSY;
      end else if (w_gnt[PORT_CPU]) begin
        r_owner <= PORT_CPU;
        s_addr  <= m0_addr;
        s_wdata <= m0_wdata;
        s_wstrb <= m0_wstrb;
        s_valid <= 1'b1;
        r_state <= ST_BUSY;
      end
    end else if (w_fin) begin
      // Completion always passes through IDLE, guaranteeing a gap between transactions.
      s_valid <= 1'b0;
      r_prio  <= ~r_owner;
      r_state <= ST_IDLE;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - self-checking bench for mem_bus_arbiter (timeout test under MEM_BUS_ARB_TIMEOUT_EN)
module tb_mem_bus_arbiter;

  localparam int TMO = 16;
`ifdef MEM_BUS_ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m0_valid = 1'b0, m1_valid = 1'b0;
  logic [31:0] m0_addr = '0, m1_addr = '0, m0_wdata = '0, m1_wdata = '0;
  logic [3:0]  m0_wstrb = '0, m1_wstrb = '0;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_ready = 1'b0;
  logic [31:0] s_rdata = '0;
  logic        m_err;

  int n_vec = 0;
  int n_err = 0;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_ready(s_ready), .s_rdata(s_rdata), .m_err(m_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level model: at most one outstanding transaction, owner and preference tracked as ints.
  int          mb_busy = 0, mb_owner = 0, mb_prio = 0, mb_wait = 0, mb_win;
  logic [31:0] mb_addr = '0, mb_wdata = '0;
  logic [3:0]  mb_wstrb = '0;
  bit          m_done, m_tmo;

  always @(negedge clk) begin
    m_done = (mb_busy != 0) && s_ready;
    m_tmo  = TMO_EN && (mb_busy != 0) && !s_ready && (mb_wait == TMO - 1);
    chk("mon_s_valid", s_valid, mb_busy != 0);
    chk("mon_s_addr", s_addr, mb_addr);
    chk("mon_s_wdata", s_wdata, mb_wdata);
    chk("mon_s_wstrb", s_wstrb, mb_wstrb);
    chk("mon_m0_ready", m0_ready, (m_done || m_tmo) && mb_owner == 0);
    chk("mon_m1_ready", m1_ready, (m_done || m_tmo) && mb_owner == 1);
    chk("mon_m_err", m_err, m_tmo);
    chk("mon_m0_rdata", m0_rdata, (m_tmo && mb_owner == 0) ? 32'hDEAD_BEEF : s_rdata);
    chk("mon_m1_rdata", m1_rdata, (m_tmo && mb_owner == 1) ? 32'hDEAD_BEEF : s_rdata);
    if (reset) begin
      mb_busy = 0; mb_owner = 0; mb_prio = 0; mb_wait = 0;
      mb_addr = '0; mb_wdata = '0; mb_wstrb = '0;
    end else if (mb_busy == 0) begin
      mb_win = -1;
      if (m0_valid && m1_valid) mb_win = mb_prio;
      else if (m0_valid)        mb_win = 0;
      else if (m1_valid)        mb_win = 1;
      if (mb_win >= 0) begin
        mb_busy  = 1;
        mb_owner = mb_win;
        mb_addr  = (mb_win == 1) ? m1_addr  : m0_addr;
        mb_wdata = (mb_win == 1) ? m1_wdata : m0_wdata;
        mb_wstrb = (mb_win == 1) ? m1_wstrb : m0_wstrb;
        mb_wait  = 0;
      end
    end else if (m_done || m_tmo) begin
      mb_busy = 0;
      mb_prio = 1 - mb_owner;
    end else begin
      mb_wait++;
    end
  end

  initial begin
    #60000;
    $display("FAIL sim_timeout: simulation did not reach the end");
    $fatal(1, "time limit");
  end

  logic [31:0] got[$];
  logic [31:0] exp_order[4];

  initial begin
    exp_order = '{32'h100, 32'h200, 32'h100, 32'h200};
    step(); step();
    chk("reset_s_valid", s_valid, 1'b0);
    chk("reset_s_addr", s_addr, 32'h0);
    reset = 1'b0;

    // Single m0 read
    m0_valid = 1'b1; m0_addr = 32'h2010_0028; m0_wstrb = 4'b0000;
    step();
    chk("rd_s_valid", s_valid, 1'b1);
    chk("rd_s_addr", s_addr, 32'h2010_0028);
    step(); step();
    s_ready = 1'b1; s_rdata = 32'h1234_5678;
    #2;
    chk("rd_m0_ready", m0_ready, 1'b1);
    chk("rd_m0_rdata", m0_rdata, 32'h1234_5678);
    chk("rd_m1_ready", m1_ready, 1'b0);
    step();
    m0_valid = 1'b0; s_ready = 1'b0;
    chk("rd_done_s_valid", s_valid, 1'b0);

    // Simultaneous requests after reset alternate m0, m1, ...
    reset = 1'b1; step(); reset = 1'b0;
    m0_valid = 1'b1; m0_addr = 32'h100;
    m1_valid = 1'b1; m1_addr = 32'h200; m1_wstrb = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      int guard = 0;
      while (!s_valid && guard < 8) begin step(); guard++; end
      if (guard == 8) chk("rr_wait_bound", 1'b0, 1'b1);
      got.push_back(s_addr);
      s_ready = 1'b1; s_rdata = 32'hC0DE_0000 + k;
      step();
      s_ready = 1'b0;
      chk("rr_idle_gap", s_valid, 1'b0);
    end
    m0_valid = 1'b0; m1_valid = 1'b0;
    chk("rr_count", got.size(), 4);
    for (int k = 0; k < 4 && k < got.size(); k++) chk("rr_order", got[k], exp_order[k]);

    // m1 write, request fields ignored while busy
    m1_valid = 1'b1; m1_addr = 32'h300; m1_wdata = 32'hAABB_CCDD; m1_wstrb = 4'b0011;
    step();
    chk("wr_s_wstrb", s_wstrb, 4'b0011);
    chk("wr_s_wdata", s_wdata, 32'hAABB_CCDD);
    m1_wdata = 32'h0;
    step();
    chk("wr_s_wdata_hold", s_wdata, 32'hAABB_CCDD);
    s_ready = 1'b1;
    #2;
    chk("wr_m1_ready", m1_ready, 1'b1);
    chk("wr_m0_ready", m0_ready, 1'b0);
    step();
    m1_valid = 1'b0; s_ready = 1'b0; m1_wstrb = 4'b0000;

    // Spurious s_ready while idle
    s_ready = 1'b1;
    #2;
    chk("sp_m0_ready", m0_ready, 1'b0);
    chk("sp_m1_ready", m1_ready, 1'b0);
    step();
    chk("sp_s_valid", s_valid, 1'b0);
    s_ready = 1'b0;

    // Reset while busy: abandon and return preference to m0
    m0_valid = 1'b1; m0_addr = 32'h500;
    step();
    s_ready = 1'b1;
    step();
    m0_valid = 1'b0; s_ready = 1'b0;
    m1_valid = 1'b1; m1_addr = 32'h400;
    step();
    chk("rst_busy_s_addr", s_addr, 32'h400);
    reset = 1'b1;
    step();
    chk("rst_s_valid", s_valid, 1'b0);
    chk("rst_m1_ready", m1_ready, 1'b0);
    reset = 1'b0;
    m0_valid = 1'b1; m0_addr = 32'h600;
    step();
    chk("rst_prio_m0", s_addr, 32'h600);
    s_ready = 1'b1;
    step();
    m0_valid = 1'b0; s_ready = 1'b0;
    step();
    chk("rst_next_m1", s_addr, 32'h400);
    s_ready = 1'b1;
    step();
    m1_valid = 1'b0; s_ready = 1'b0;
    step();

`ifdef MEM_BUS_ARB_TIMEOUT_EN
    // Watchdog: slave never answers
    m0_valid = 1'b1; m0_addr = 32'h700;
    step();
    repeat (14) step();
    chk("tmo_early_ready", m0_ready, 1'b0);
    chk("tmo_early_err", m_err, 1'b0);
    step();
    chk("tmo_m0_ready", m0_ready, 1'b1);
    chk("tmo_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
    chk("tmo_m_err", m_err, 1'b1);
    m0_valid = 1'b0;
    step();
    chk("tmo_s_valid", s_valid, 1'b0);
    chk("tmo_err_clear", m_err, 1'b0);
`endif

    step(); step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
